// File: rtl/z85_regbank_pkg.sv
// ----------------------------------------------------------------------------
// z85_regbank_pkg
// Shared definitions for the Z85 register bank:
//   - register-pair index constants used on every select port
//   - dump sequencer state encoding
//   - dump entry-count helper (active pairs plus shadow banks)
// ----------------------------------------------------------------------------
package z85_regbank_pkg;

    localparam logic [3:0] IDX_BC = 4'd0;
    localparam logic [3:0] IDX_DE = 4'd1;
    localparam logic [3:0] IDX_HL = 4'd2;
    localparam logic [3:0] IDX_AF = 4'd3;
    localparam logic [3:0] IDX_IX = 4'd4;
    localparam logic [3:0] IDX_IY = 4'd5;
    localparam logic [3:0] IDX_SP = 4'd6;
    localparam logic [3:0] IDX_PC = 4'd7;
    localparam logic [3:0] IDX_WZ = 4'd8;
    localparam logic [3:0] IDX_IR = 4'd9;

    // Number of architecturally visible pairs; indices at or above are reserved.
    localparam int NUM_PAIRS = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DUMP = 1'b1
    } dump_state_t;

    // Ten active pairs, then BC/DE/HL/AF for every non-active bank.
    function automatic int dump_entries(input int nbanks);
        return NUM_PAIRS + 4 * (nbanks - 1);
    endfunction

endpackage

// File: rtl/z85_regbank_dump.sv
// ----------------------------------------------------------------------------
// z85_regbank_dump
// Debug dump sequencer. Walks every register entry once per dbg_req using a
// valid/ready handshake and tells the parent which pair and bank offset to
// present on dbg_data.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   dbg_req             start a dump (ignored while one is running)
//   dbg_ready           consumer accepts the presented entry
//   dbg_valid, dbg_busy high for the whole dump
//   dbg_idx             entry currently presented
//   rd_idx              pair index the parent must read for this entry
//   bank_off            bank offset from the active bank (0 = active)
// ----------------------------------------------------------------------------
module z85_regbank_dump
    import z85_regbank_pkg::*;
#(
    parameter int NBANKS = 2,
    parameter int IW     = 4,
    parameter int BW     = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dbg_req,
    input  logic          dbg_ready,
    output logic          dbg_valid,
    output logic          dbg_busy,
    output logic [IW-1:0] dbg_idx,
    output logic [3:0]    rd_idx,
    output logic [BW-1:0] bank_off
);

    localparam logic [IW-1:0] LAST_IDX = IW'(dump_entries(NBANKS) - 1);

    dump_state_t   state;
    dump_state_t   state_d;
    logic [IW-1:0] idx_d;
    int            entry;

    // State and entry index registers; reset aborts a dump immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            dbg_idx <= '0;
        end else begin
            state   <= state_d;
            dbg_idx <= idx_d;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d   = state;
        idx_d     = dbg_idx;
        dbg_valid = 1'b0;
        dbg_busy  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dbg_req) begin
                    state_d = ST_DUMP;
                    idx_d   = '0;
                end
            end
            ST_DUMP: begin
                dbg_valid = 1'b1;
                dbg_busy  = 1'b1;
                if (dbg_ready) begin
                    if (dbg_idx == LAST_IDX) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = dbg_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Entry-to-register mapping: the first ten entries are the active pairs,
    // then groups of four (BC, DE, HL, AF) for bank offsets 1..NBANKS-1.
    always_comb begin
        entry    = int'(dbg_idx) - NUM_PAIRS;
        rd_idx   = 4'(dbg_idx);
        bank_off = '0;
        if (dbg_idx >= IW'(NUM_PAIRS)) begin
            rd_idx   = {2'b00, entry[1:0]};
            bank_off = BW'((entry >> 2) + 1);
        end
    end

endmodule

// File: rtl/z85_regbank.sv
// ----------------------------------------------------------------------------
// z85_regbank
// Z85 CPU register file: banked BC/DE/HL and AF, unbanked IX/IY/SP/PC/WZ/IR,
// NRD combinational read ports, two byte-enabled write ports, bank rotation,
// refresh counter increment and a handshaked debug dump of every entry.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   rd_sel[NRD] / rd_data[NRD]    read pair select / pair value (hi byte first)
//   wrN_en/sel/be/data (N=0,1)    write ports, be[1] = high byte, wr0 wins
//   exx_req, exaf_req             rotate BC/DE/HL bank, rotate AF bank
//   r_inc                         increment R[6:0], keeping R[7]
//   dbg_req/valid/ready/idx/data/busy   debug dump interface
// ----------------------------------------------------------------------------
module z85_regbank
    import z85_regbank_pkg::*;
#(
    parameter int NBANKS = 2,
    parameter int NRD    = 3,
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  rd_sel  [NRD],
    output logic [15:0] rd_data [NRD],
    input  logic        wr0_en,
    input  logic [3:0]  wr0_sel,
    input  logic [1:0]  wr0_be,
    input  logic [15:0] wr0_data,
    input  logic        wr1_en,
    input  logic [3:0]  wr1_sel,
    input  logic [1:0]  wr1_be,
    input  logic [15:0] wr1_data,
    input  logic        exx_req,
    input  logic        exaf_req,
    input  logic        r_inc,
    input  logic        dbg_req,
    output logic        dbg_valid,
    input  logic        dbg_ready,
    output logic [$clog2(dump_entries(NBANKS))-1:0] dbg_idx,
    output logic [15:0] dbg_data,
    output logic        dbg_busy
);

    localparam int BW = $clog2(NBANKS);
    localparam int IW = $clog2(dump_entries(NBANKS));

    logic [15:0] bc_q [NBANKS];
    logic [15:0] de_q [NBANKS];
    logic [15:0] hl_q [NBANKS];
    logic [15:0] af_q [NBANKS];
    logic [15:0] ix_q, iy_q, sp_q, pc_q, wz_q, ir_q;
    logic [BW-1:0] reg_bank, af_bank;

    logic [NUM_PAIRS-1:0] hi_hit, lo_hit;
    logic [7:0]           hi_val [NUM_PAIRS];
    logic [7:0]           lo_val [NUM_PAIRS];
    logic [15:0]          act    [NUM_PAIRS];
    logic [15:0]          fwd    [NUM_PAIRS];
    logic [15:0]          ir_inc;

    logic [3:0]    dump_rd_idx;
    logic [BW-1:0] dump_off;
    logic [BW-1:0] dump_rb, dump_ab;

    function automatic logic [15:0] merge(input logic [15:0] cur,
                                          input logic hh, input logic [7:0] hv,
                                          input logic lh, input logic [7:0] lv);
        return {(hh ? hv : cur[15:8]), (lh ? lv : cur[7:0])};
    endfunction

    // Per-pair byte write decode. wr1 is applied first so wr0 overrides it on
    // a shared byte; reserved selects never match a pair and are dropped.
    always_comb begin
        for (int p = 0; p < NUM_PAIRS; p++) begin
            hi_hit[p] = 1'b0;
            lo_hit[p] = 1'b0;
            hi_val[p] = 8'h00;
            lo_val[p] = 8'h00;
            if (wr1_en && wr1_sel == 4'(p)) begin
                if (wr1_be[1]) begin hi_hit[p] = 1'b1; hi_val[p] = wr1_data[15:8]; end
                if (wr1_be[0]) begin lo_hit[p] = 1'b1; lo_val[p] = wr1_data[7:0]; end
            end
            if (wr0_en && wr0_sel == 4'(p)) begin
                if (wr0_be[1]) begin hi_hit[p] = 1'b1; hi_val[p] = wr0_data[15:8]; end
                if (wr0_be[0]) begin lo_hit[p] = 1'b1; lo_val[p] = wr0_data[7:0]; end
            end
        end
    end

    // Active-bank view of all pairs, plus the same view with this cycle's
    // writes forwarded in when bypass is enabled.
    always_comb begin
        act[IDX_BC] = bc_q[reg_bank];
        act[IDX_DE] = de_q[reg_bank];
        act[IDX_HL] = hl_q[reg_bank];
        act[IDX_AF] = af_q[af_bank];
        act[IDX_IX] = ix_q;
        act[IDX_IY] = iy_q;
        act[IDX_SP] = sp_q;
        act[IDX_PC] = pc_q;
        act[IDX_WZ] = wz_q;
        act[IDX_IR] = ir_q;
        for (int p = 0; p < NUM_PAIRS; p++) begin
            fwd[p] = act[p];
            if (BYPASS != 0) begin
                fwd[p] = merge(act[p], hi_hit[p], hi_val[p], lo_hit[p], lo_val[p]);
            end
        end
    end

    // Combinational read ports; reserved indices read as zero.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_data[i] = 16'h0000;
            if (rd_sel[i] < 4'(NUM_PAIRS)) begin
                rd_data[i] = fwd[rd_sel[i]];
            end
        end
    end

    // Refresh increment keeps R[7]; a low-byte write is merged on top of it.
    assign ir_inc = r_inc ? {ir_q[15:7], ir_q[6:0] + 7'd1} : ir_q;

    // Register state. Writes address the banks selected before any rotate in
    // the same cycle, since reg_bank/af_bank update on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NBANKS; b++) begin
                bc_q[b] <= 16'h0000;
                de_q[b] <= 16'h0000;
                hl_q[b] <= 16'h0000;
                af_q[b] <= 16'hFFFF;
            end
            ix_q     <= 16'h0000;
            iy_q     <= 16'h0000;
            sp_q     <= 16'hFFFF;
            pc_q     <= 16'h0000;
            wz_q     <= 16'h0000;
            ir_q     <= 16'h0000;
            reg_bank <= '0;
            af_bank  <= '0;
        end else begin
            bc_q[reg_bank] <= merge(bc_q[reg_bank], hi_hit[IDX_BC], hi_val[IDX_BC], lo_hit[IDX_BC], lo_val[IDX_BC]);
            de_q[reg_bank] <= merge(de_q[reg_bank], hi_hit[IDX_DE], hi_val[IDX_DE], lo_hit[IDX_DE], lo_val[IDX_DE]);
            hl_q[reg_bank] <= merge(hl_q[reg_bank], hi_hit[IDX_HL], hi_val[IDX_HL], lo_hit[IDX_HL], lo_val[IDX_HL]);
            af_q[af_bank]  <= merge(af_q[af_bank],  hi_hit[IDX_AF], hi_val[IDX_AF], lo_hit[IDX_AF], lo_val[IDX_AF]);
            ix_q <= merge(ix_q,   hi_hit[IDX_IX], hi_val[IDX_IX], lo_hit[IDX_IX], lo_val[IDX_IX]);
            iy_q <= merge(iy_q,   hi_hit[IDX_IY], hi_val[IDX_IY], lo_hit[IDX_IY], lo_val[IDX_IY]);
            sp_q <= merge(sp_q,   hi_hit[IDX_SP], hi_val[IDX_SP], lo_hit[IDX_SP], lo_val[IDX_SP]);
            pc_q <= merge(pc_q,   hi_hit[IDX_PC], hi_val[IDX_PC], lo_hit[IDX_PC], lo_val[IDX_PC]);
            wz_q <= merge(wz_q,   hi_hit[IDX_WZ], hi_val[IDX_WZ], lo_hit[IDX_WZ], lo_val[IDX_WZ]);
            ir_q <= merge(ir_inc, hi_hit[IDX_IR], hi_val[IDX_IR], lo_hit[IDX_IR], lo_val[IDX_IR]);
            if (exx_req) begin
                reg_bank <= reg_bank + 1'b1;
            end
            if (exaf_req) begin
                af_bank <= af_bank + 1'b1;
            end
        end
    end

    z85_regbank_dump #(
        .NBANKS (NBANKS),
        .IW     (IW),
        .BW     (BW)
    ) u_dump (
        .clk       (clk),
        .rst_n     (rst_n),
        .dbg_req   (dbg_req),
        .dbg_ready (dbg_ready),
        .dbg_valid (dbg_valid),
        .dbg_busy  (dbg_busy),
        .dbg_idx   (dbg_idx),
        .rd_idx    (dump_rd_idx),
        .bank_off  (dump_off)
    );

    assign dump_rb = reg_bank + dump_off;
    assign dump_ab = af_bank + dump_off;

    // Dump data is live. Offset 0 shares the read-port path (including
    // forwarding); shadow banks can never be the target of a same-cycle write.
    always_comb begin
        dbg_data = 16'h0000;
        if (dump_off == '0) begin
            if (dump_rd_idx < 4'(NUM_PAIRS)) begin
                dbg_data = fwd[dump_rd_idx];
            end
        end else begin
            case (dump_rd_idx)
                IDX_BC:  dbg_data = bc_q[dump_rb];
                IDX_DE:  dbg_data = de_q[dump_rb];
                IDX_HL:  dbg_data = hl_q[dump_rb];
                IDX_AF:  dbg_data = af_q[dump_ab];
                default: dbg_data = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_z85_regbank.sv
// ----------------------------------------------------------------------------
// tb_z85_regbank
// Self-checking bench for z85_regbank (NBANKS=2, NRD=3, BYPASS=1).
// ----------------------------------------------------------------------------
module tb_z85_regbank;
    import z85_regbank_pkg::*;

    localparam int NBANKS = 2;
    localparam int NRD    = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  rd_sel  [NRD];
    logic [15:0] rd_data [NRD];
    logic        wr0_en, wr1_en;
    logic [3:0]  wr0_sel, wr1_sel;
    logic [1:0]  wr0_be, wr1_be;
    logic [15:0] wr0_data, wr1_data;
    logic        exx_req, exaf_req, r_inc;
    logic        dbg_req, dbg_valid, dbg_ready, dbg_busy;
    logic [3:0]  dbg_idx;
    logic [15:0] dbg_data;

    typedef struct {
        logic        w0en;
        logic [3:0]  w0sel;
        logic [1:0]  w0be;
        logic [15:0] w0d;
        logic        w1en;
        logic [3:0]  w1sel;
        logic [1:0]  w1be;
        logic [15:0] w1d;
        logic        exx;
        logic        exaf;
        logic        rinc;
        logic [3:0]  sel0;
        logic [15:0] exp0;
        logic [3:0]  sel1;
        logic [15:0] exp1;
    } vec_t;

    typedef struct {
        int          id;
        logic [15:0] exp0;
        logic [15:0] exp1;
    } sb_t;

    typedef struct {
        logic [3:0]  idx;
        logic [15:0] data;
    } dump_t;

    vec_t  vecs[$];
    sb_t   sb_q[$];
    dump_t dump_q[$];
    int    vec_count  = 0;
    int    miss_count = 0;

    z85_regbank #(
        .NBANKS (NBANKS),
        .NRD    (NRD),
        .BYPASS (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .wr0_en    (wr0_en),
        .wr0_sel   (wr0_sel),
        .wr0_be    (wr0_be),
        .wr0_data  (wr0_data),
        .wr1_en    (wr1_en),
        .wr1_sel   (wr1_sel),
        .wr1_be    (wr1_be),
        .wr1_data  (wr1_data),
        .exx_req   (exx_req),
        .exaf_req  (exaf_req),
        .r_inc     (r_inc),
        .dbg_req   (dbg_req),
        .dbg_valid (dbg_valid),
        .dbg_ready (dbg_ready),
        .dbg_idx   (dbg_idx),
        .dbg_data  (dbg_data),
        .dbg_busy  (dbg_busy)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        wr0_en = 1'b0; wr0_sel = 4'd0; wr0_be = 2'b00; wr0_data = 16'h0000;
        wr1_en = 1'b0; wr1_sel = 4'd0; wr1_be = 2'b00; wr1_data = 16'h0000;
        exx_req = 1'b0; exaf_req = 1'b0; r_inc = 1'b0;
        dbg_req = 1'b0; dbg_ready = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int id);
        wr0_en = v.w0en; wr0_sel = v.w0sel; wr0_be = v.w0be; wr0_data = v.w0d;
        wr1_en = v.w1en; wr1_sel = v.w1sel; wr1_be = v.w1be; wr1_data = v.w1d;
        exx_req = v.exx; exaf_req = v.exaf; r_inc = v.rinc;
        rd_sel[0] = v.sel0;
        rd_sel[1] = v.sel1;
        rd_sel[2] = IDX_PC;
        sb_q.push_back('{id: id, exp0: v.exp0, exp1: v.exp1});
    endtask

    function automatic vec_t mkv(
        input logic w0en, input logic [3:0] w0sel, input logic [1:0] w0be, input logic [15:0] w0d,
        input logic w1en, input logic [3:0] w1sel, input logic [1:0] w1be, input logic [15:0] w1d,
        input logic exx, input logic exaf, input logic rinc,
        input logic [3:0] sel0, input logic [15:0] exp0,
        input logic [3:0] sel1, input logic [15:0] exp1);
        vec_t v;
        v.w0en = w0en; v.w0sel = w0sel; v.w0be = w0be; v.w0d = w0d;
        v.w1en = w1en; v.w1sel = w1sel; v.w1be = w1be; v.w1d = w1d;
        v.exx = exx; v.exaf = exaf; v.rinc = rinc;
        v.sel0 = sel0; v.exp0 = exp0; v.sel1 = sel1; v.exp1 = exp1;
        return v;
    endfunction

    // Expected read values are same-cycle, so they include forwarded writes
    // but not the effect of the rotate or increment happening on that edge.
    initial begin
        sb_t   sb;
        dump_t de;
        logic  rdy;
        int    cycles;
        logic [15:0] exp_b [5];

        idleInputs();
        rd_sel[0] = IDX_BC; rd_sel[1] = IDX_BC; rd_sel[2] = IDX_BC;
        rst_n = 1'b0;
        #12;
        checkOutput("reset.dbg_valid", {15'd0, dbg_valid}, 16'h0000);
        checkOutput("reset.dbg_busy",  {15'd0, dbg_busy},  16'h0000);
        checkOutput("reset.dbg_idx",   {12'd0, dbg_idx},   16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        //              w0en w0sel   be    w0d       w1en w1sel   be    w1d       exx  exaf rinc sel0    exp0      sel1    exp1
        vecs.push_back(mkv(0, IDX_BC, 2'd0, 16'h0000, 0, IDX_BC, 2'd0, 16'h0000, 0, 0, 0, IDX_AF, 16'hFFFF, IDX_SP, 16'hFFFF));
        vecs.push_back(mkv(1, IDX_BC, 2'd3, 16'h1234, 0, IDX_BC, 2'd0, 16'h0000, 1, 0, 0, IDX_BC, 16'h1234, IDX_DE, 16'h0000));
        vecs.push_back(mkv(0, IDX_BC, 2'd0, 16'h0000, 0, IDX_BC, 2'd0, 16'h0000, 0, 0, 0, IDX_BC, 16'h0000, IDX_HL, 16'h0000));
        vecs.push_back(mkv(0, IDX_BC, 2'd0, 16'h0000, 0, IDX_BC, 2'd0, 16'h0000, 1, 0, 0, IDX_BC, 16'h0000, IDX_AF, 16'hFFFF));
        vecs.push_back(mkv(0, IDX_BC, 2'd0, 16'h0000, 0, IDX_BC, 2'd0, 16'h0000, 0, 0, 0, IDX_BC, 16'h1234, IDX_IX, 16'h0000));
        vecs.push_back(mkv(1, IDX_HL, 2'd2, 16'hAA99, 1, IDX_HL, 2'd3, 16'h5566, 0, 0, 0, IDX_HL, 16'hAA66, 4'd10,  16'h0000));
        vecs.push_back(mkv(0, IDX_BC, 2'd0, 16'h0000, 0, IDX_BC, 2'd0, 16'h0000, 0, 0, 0, IDX_HL, 16'hAA66, IDX_BC, 16'h1234));
        vecs.push_back(mkv(1, 4'd12,  2'd3, 16'hBEEF, 1, IDX_BC, 2'd1, 16'h00CD, 0, 0, 0, IDX_BC, 16'h12CD, 4'd12,  16'h0000));
        vecs.push_back(mkv(0, IDX_BC, 2'd0, 16'h0000, 0, IDX_BC, 2'd0, 16'h0000, 0, 0, 0, IDX_BC, 16'h12CD, 4'd15,  16'h0000));
        vecs.push_back(mkv(1, IDX_IR, 2'd1, 16'h00FF, 0, IDX_BC, 2'd0, 16'h0000, 0, 0, 0, IDX_IR, 16'h00FF, IDX_SP, 16'hFFFF));
        vecs.push_back(mkv(0, IDX_BC, 2'd0, 16'h0000, 0, IDX_BC, 2'd0, 16'h0000, 0, 0, 1, IDX_IR, 16'h00FF, IDX_IR, 16'h00FF));
        vecs.push_back(mkv(0, IDX_BC, 2'd0, 16'h0000, 0, IDX_BC, 2'd0, 16'h0000, 0, 0, 1, IDX_IR, 16'h0080, IDX_SP, 16'hFFFF));
        vecs.push_back(mkv(1, IDX_IR, 2'd1, 16'h0012, 0, IDX_BC, 2'd0, 16'h0000, 0, 0, 1, IDX_IR, 16'h0012, IDX_BC, 16'h12CD));
        vecs.push_back(mkv(0, IDX_BC, 2'd0, 16'h0000, 0, IDX_BC, 2'd0, 16'h0000, 0, 0, 0, IDX_IR, 16'h0012, IDX_DE, 16'h0000));
        vecs.push_back(mkv(1, IDX_IR, 2'd1, 16'h0034, 1, IDX_IR, 2'd2, 16'h5600, 0, 0, 0, IDX_IR, 16'h5634, IDX_HL, 16'hAA66));
        vecs.push_back(mkv(1, IDX_AF, 2'd3, 16'h0102, 0, IDX_BC, 2'd0, 16'h0000, 0, 1, 0, IDX_AF, 16'h0102, IDX_BC, 16'h12CD));
        vecs.push_back(mkv(0, IDX_BC, 2'd0, 16'h0000, 0, IDX_BC, 2'd0, 16'h0000, 0, 0, 0, IDX_AF, 16'hFFFF, IDX_BC, 16'h12CD));
        vecs.push_back(mkv(0, IDX_BC, 2'd0, 16'h0000, 1, IDX_DE, 2'd3, 16'h7788, 1, 1, 0, IDX_DE, 16'h7788, IDX_AF, 16'hFFFF));
        vecs.push_back(mkv(0, IDX_BC, 2'd0, 16'h0000, 0, IDX_BC, 2'd0, 16'h0000, 0, 0, 0, IDX_AF, 16'h0102, IDX_DE, 16'h0000));
        vecs.push_back(mkv(0, IDX_BC, 2'd0, 16'h0000, 0, IDX_BC, 2'd0, 16'h0000, 1, 0, 0, IDX_DE, 16'h0000, IDX_PC, 16'h0000));
        vecs.push_back(mkv(0, IDX_BC, 2'd0, 16'h0000, 0, IDX_BC, 2'd0, 16'h0000, 0, 0, 0, IDX_DE, 16'h7788, IDX_AF, 16'h0102));
        vecs.push_back(mkv(1, IDX_PC, 2'd3, 16'h4321, 1, IDX_WZ, 2'd3, 16'h9ABC, 0, 0, 0, IDX_PC, 16'h4321, IDX_WZ, 16'h9ABC));
        vecs.push_back(mkv(0, IDX_BC, 2'd0, 16'h0000, 0, IDX_BC, 2'd0, 16'h0000, 1, 0, 0, IDX_PC, 16'h4321, IDX_WZ, 16'h9ABC));
        vecs.push_back(mkv(0, IDX_BC, 2'd0, 16'h0000, 0, IDX_BC, 2'd0, 16'h0000, 1, 0, 0, IDX_IX, 16'h0000, IDX_IY, 16'h0000));

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i], i);
            #2;
            sb = sb_q.pop_front();
            checkOutput($sformatf("vec%0d.rd0", sb.id), rd_data[0], sb.exp0);
            checkOutput($sformatf("vec%0d.rd1", sb.id), rd_data[1], sb.exp1);
        end

        // Dump of the accumulated state with ready toggling every cycle.
        @(negedge clk);
        idleInputs();
        dbg_req = 1'b1;
        foreach (vecs[i]) begin end
        dump_q.push_back('{4'd0,  16'h12CD});
        dump_q.push_back('{4'd1,  16'h7788});
        dump_q.push_back('{4'd2,  16'hAA66});
        dump_q.push_back('{4'd3,  16'h0102});
        dump_q.push_back('{4'd4,  16'h0000});
        dump_q.push_back('{4'd5,  16'h0000});
        dump_q.push_back('{4'd6,  16'hFFFF});
        dump_q.push_back('{4'd7,  16'h4321});
        dump_q.push_back('{4'd8,  16'h9ABC});
        dump_q.push_back('{4'd9,  16'h5634});
        dump_q.push_back('{4'd10, 16'h0000});
        dump_q.push_back('{4'd11, 16'h0000});
        dump_q.push_back('{4'd12, 16'h0000});
        dump_q.push_back('{4'd13, 16'hFFFF});
        @(negedge clk);
        rdy    = 1'b0;
        cycles = 0;
        while (dump_q.size() > 0 && cycles < 100) begin
            dbg_ready = rdy;
            dbg_req   = (cycles == 6);
            #2;
            checkOutput("dumpA.valid", {15'd0, dbg_valid}, 16'h0001);
            checkOutput("dumpA.busy",  {15'd0, dbg_busy},  16'h0001);
            if (rdy) begin
                de = dump_q.pop_front();
                checkOutput($sformatf("dumpA.idx%0d", de.idx),  {12'd0, dbg_idx}, {12'd0, de.idx});
                checkOutput($sformatf("dumpA.data%0d", de.idx), dbg_data, de.data);
            end else begin
                checkOutput("dumpA.hold_idx", {12'd0, dbg_idx}, {12'd0, dump_q[0].idx});
            end
            rdy = ~rdy;
            cycles++;
            @(negedge clk);
        end
        checkOutput("dumpA.entries_left", 16'(dump_q.size()), 16'h0000);
        dbg_ready = 1'b0;
        dbg_req   = 1'b0;
        #2;
        checkOutput("dumpA.busy_after", {15'd0, dbg_busy},  16'h0000);
        checkOutput("dumpA.valid_after", {15'd0, dbg_valid}, 16'h0000);

        // Reset, then abort a dump in progress at entry 5.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_sel[0] = IDX_AF; rd_sel[1] = IDX_SP; rd_sel[2] = IDX_BC;
        #2;
        checkOutput("rst2.af", rd_data[0], 16'hFFFF);
        checkOutput("rst2.sp", rd_data[1], 16'hFFFF);
        checkOutput("rst2.bc", rd_data[2], 16'h0000);
        exp_b[0] = 16'h0000; exp_b[1] = 16'h0000; exp_b[2] = 16'h0000;
        exp_b[3] = 16'hFFFF; exp_b[4] = 16'h0000;
        @(negedge clk);
        dbg_req = 1'b1;
        @(negedge clk);
        dbg_req   = 1'b0;
        dbg_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #2;
            checkOutput($sformatf("dumpB.idx%0d", k),  {12'd0, dbg_idx}, 16'(k));
            checkOutput($sformatf("dumpB.data%0d", k), dbg_data, exp_b[k]);
            @(negedge clk);
        end
        #2;
        checkOutput("dumpB.idx5", {12'd0, dbg_idx}, 16'd5);
        rst_n = 1'b0;
        #1;
        checkOutput("abort.valid", {15'd0, dbg_valid}, 16'h0000);
        checkOutput("abort.busy",  {15'd0, dbg_busy},  16'h0000);
        checkOutput("abort.idx",   {12'd0, dbg_idx},   16'h0000);
        @(negedge clk);
        rst_n     = 1'b1;
        dbg_ready = 1'b0;
        rd_sel[0] = IDX_SP; rd_sel[1] = IDX_AF;
        #2;
        checkOutput("release.sp", rd_data[0], 16'hFFFF);
        checkOutput("release.af", rd_data[1], 16'hFFFF);
        checkOutput("release.valid", {15'd0, dbg_valid}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/z85_regbank.md
Z85_REGBANK -- requirements
Module: z85_regbank

Interface
REQ-001 SHALL have parameter NBANKS, default 2, number of BC/DE/HL and AF register banks (power of two, >=2).
REQ-002 SHALL have parameter NRD, default 3, number of combinational 16-bit read ports.
REQ-003 SHALL have parameter BYPASS, default 1, which enables same-cycle write-to-read forwarding.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rd_sel[NRD], input, 4 bits each: pair index (0 BC, 1 DE, 2 HL, 3 AF, 4 IX, 5 IY, 6 SP, 7 PC, 8 WZ, 9 IR; 10-15 reserved).
REQ-007 SHALL have port rd_data[NRD], output, 16 bits each: selected pair, high byte first.
REQ-008 SHALL have ports wrN_en (1), wrN_sel (4), wrN_be (2, bit1 = high byte), wrN_data (16), inputs, for N = 0,1.
REQ-009 SHALL have ports exx_req and exaf_req, inputs, 1 bit each: bank-rotate strobes.
REQ-010 SHALL have port r_inc, input, 1 bit: opcode-fetch refresh increment.
REQ-011 SHALL have ports dbg_req (in, 1), dbg_valid (out, 1), dbg_ready (in, 1), dbg_idx (out, clog2(10+4*(NBANKS-1))), dbg_data (out, 16), dbg_busy (out, 1).

Function
REQ-012 Reads SHALL be combinational from the active bank; reserved indices SHALL read 16'h0000.
REQ-013 Writes SHALL update only the bytes enabled by wrN_be; writes to reserved indices SHALL be ignored.
REQ-014 When both write ports target the same byte in one cycle, wr0 SHALL win.
REQ-015 When BYPASS=1, rd_data SHALL return the same-cycle write byte (wr0 over wr1); when BYPASS=0, it SHALL return the pre-edge value.
REQ-016 exx_req SHALL set reg_bank to (reg_bank+1) mod NBANKS, and exaf_req SHALL set af_bank to (af_bank+1) mod NBANKS; both in the same cycle SHALL rotate both.
REQ-017 A write in the same cycle as a rotate SHALL land in the pre-rotate bank.
REQ-018 IX, IY, SP, PC, WZ and IR SHALL be unbanked.
REQ-019 r_inc SHALL do R[6:0] <= R[6:0]+1, preserving R[7], with 7'h7F wrapping to 7'h00.
REQ-020 A write to the IR low byte in the same cycle as r_inc SHALL win over the increment.
REQ-021 The dump FSM SHALL have two states: IDLE and DUMP.
- IDLE -> DUMP on dbg_req; dbg_idx <= 0.
- In DUMP: dbg_valid = 1; dbg_busy = 1.
- Entry ordering: entries 0-9 are active indices 0-9.
- For k = 1..NBANKS-1: BC, DE, HL of bank (reg_bank+k) mod NBANKS, then AF of (af_bank+k) mod NBANKS.
REQ-022 dbg_data SHALL reflect live contents in the handshake cycle.
REQ-023 dbg_idx SHALL advance only on dbg_valid && dbg_ready; dbg_valid and dbg_data SHALL stay stable while dbg_ready = 0, except for writes or rotates to the entry being presented.
REQ-024 After the last entry is accepted, the FSM SHALL return to IDLE next cycle, with dbg_valid = 0.
REQ-025 dbg_req while in DUMP SHALL be ignored.
REQ-026 Writes and rotates SHALL remain fully functional during DUMP.

Reset
REQ-027 On rst_n low, all banks of AF SHALL be 16'hFFFF and SP SHALL be 16'hFFFF.
REQ-028 On rst_n low, all other registers, reg_bank and af_bank SHALL be 0, and the FSM SHALL be IDLE with dbg_valid = 0, dbg_busy = 0, dbg_idx = 0.
REQ-029 Reset asserted mid-DUMP SHALL abort immediately; no partial-state hold.

Structure
REQ-030 Pair-index constants, the FSM state enum and the entry-count function SHALL live in shared package z85_regbank_pkg.
REQ-031 The dump sequencer SHALL be sub-module z85_regbank_dump.
- It owns the FSM and dbg_idx.
- It issues an internal read index and bank offset to the parent.

Verification
REQ-032 Write wr0 BC = 1234 (be = 11), exx_req; read BC -> 0000; exx_req again (NBANKS = 2); read BC -> 1234.
REQ-033 Same cycle: wr0 HL hi = AA (be = 10) and wr1 HL = 5566 (be = 11); next read HL -> AA66; with BYPASS=1, same-cycle read -> AA66.
REQ-034 R = 8'hFF, r_inc -> R = 8'h80; IR write lo = 12 together with r_inc -> R = 12.
REQ-035 NBANKS = 2, dbg_req, dbg_ready toggling every other cycle -> 14 entries, idx 0-13.
- Entry 3 = FFFF after reset.
- idx holds while ready = 0.
- dbg_busy falls one cycle after the last acceptance.
REQ-036 Assert rst_n low at dbg_idx = 5 -> dbg_valid = 0 and dbg_busy = 0 asynchronously; SP = FFFF and AF = FFFF on release.
